// File: rtl/insmem_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package insmem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCount,
    StHi,
    StLo,
    StWrite,
    StCsum,
    StDone,
    StErr
  } state_e;

  localparam int unsigned WORD_BYTES = 2;
  localparam int unsigned PC_INC     = WORD_BYTES;

endpackage

// File: rtl/insmem_loader_wrtimer.sv
// Holds the instruction-memory write enable for WR_HOLD cycles per word and
// flags the last cycle of the hold so the loader can move on.
module insmem_loader_wrtimer #(
  parameter int unsigned WR_HOLD = 2
) (
  input  logic clka,
  input  logic rst,
  input  logic fire,
  output logic we,
  output logic done
);

  localparam int unsigned CntW = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clka) begin
    if (rst) begin
      we    <= 1'b0;
      cnt_q <= '0;
    end else if (fire) begin
      we    <= 1'b1;
      cnt_q <= CntW'(WR_HOLD - 1);
    end else if (we) begin
      if (cnt_q == '0) begin
        we <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // High during the final cycle of the hold window.
  assign done = we && (cnt_q == '0);

endmodule

// File: rtl/insmem_loader.sv
// Boot loader: count byte N, then N big-endian 16-bit words into instruction memory.
// Define INSMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module insmem_loader
  import insmem_pkg::*;
#(
  parameter int unsigned PC_BITS = 6,
  parameter int unsigned WR_HOLD = 2
) (
  input  logic               clka,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               mem_we,
  output logic [PC_BITS-1:0] mem_pc,
  output logic [15:0]        mem_wdata,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err,
  output logic [PC_BITS-1:0] words_loaded
);

  localparam int unsigned Capacity = 2 ** (PC_BITS - 1);

`ifdef INSMEM_LOADER_CHECKSUM_EN
  localparam state_e EndState = StCsum;
  logic [7:0] csum_q;
`else
  localparam state_e EndState = StDone;
`endif
  localparam logic EndIsCsum = (EndState == StCsum);

  state_e     state_q;
  logic [7:0] count_q;
  logic       accept;
  logic       fire;
  logic       wr_done;

  assign accept = rx_valid && rx_ready;
  assign fire   = (state_q == StLo) && accept;

  insmem_loader_wrtimer #(
    .WR_HOLD(WR_HOLD)
  ) u_wrtimer (
    .clka(clka),
    .rst (rst),
    .fire(fire),
    .we  (mem_we),
    .done(wr_done)
  );

  always_ff @(posedge clka) begin
    if (rst) begin
      state_q      <= StIdle;
      rx_ready     <= 1'b0;
      mem_pc       <= '0;
      mem_wdata    <= '0;
      cpu_hold     <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
      count_q      <= '0;
`ifdef INSMEM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (start) begin
            state_q      <= StCount;
            rx_ready     <= 1'b1;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            mem_pc       <= '0;
            words_loaded <= '0;
          end
        end
        StCount: begin
          if (accept) begin
            count_q <= rx_data;
`ifdef INSMEM_LOADER_CHECKSUM_EN
            csum_q  <= rx_data;
`endif
            if (rx_data == 8'd0) begin
              state_q   <= EndState;
              rx_ready  <= EndIsCsum;
              cpu_hold  <= EndIsCsum;
              load_done <= !EndIsCsum;
            end else if (32'(rx_data) > Capacity) begin
              state_q  <= StErr;
              rx_ready <= 1'b0;
              load_err <= 1'b1;
            end else begin
              state_q <= StHi;
            end
          end
        end
        StHi: begin
          if (accept) begin
            mem_wdata[15:8] <= rx_data;
`ifdef INSMEM_LOADER_CHECKSUM_EN
            csum_q          <= csum_q ^ rx_data;
`endif
            state_q         <= StLo;
          end
        end
        StLo: begin
          if (accept) begin
            mem_wdata[7:0] <= rx_data;
`ifdef INSMEM_LOADER_CHECKSUM_EN
            csum_q         <= csum_q ^ rx_data;
`endif
            rx_ready       <= 1'b0;
            state_q        <= StWrite;
          end
        end
        StWrite: begin
          if (wr_done) begin
            words_loaded <= words_loaded + 1'b1;
            // With N equal to capacity the last increment wraps to 0 harmlessly.
            mem_pc       <= mem_pc + PC_BITS'(PC_INC);
            if (32'(words_loaded) + 32'd1 == 32'(count_q)) begin
              state_q   <= EndState;
              rx_ready  <= EndIsCsum;
              cpu_hold  <= EndIsCsum;
              load_done <= !EndIsCsum;
            end else begin
              state_q  <= StHi;
              rx_ready <= 1'b1;
            end
          end
        end
`ifdef INSMEM_LOADER_CHECKSUM_EN
        StCsum: begin
          if (accept) begin
            rx_ready <= 1'b0;
            if (rx_data == csum_q) begin
              state_q   <= StDone;
              cpu_hold  <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state_q  <= StErr;
              load_err <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_q  <= StIdle;
          rx_ready <= 1'b0;
          cpu_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule
